// File: rtl/rf_pkg.sv
// Shared register-file types and defaults for decode, issue and both writeback stages.
package rf_pkg;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int NR_REG_DEF     = 32;
    localparam int REG_ZERO       = 0;
    localparam int AW_DEF         = $clog2(NR_REG_DEF);

    typedef logic [AW_DEF-1:0] rf_waddr_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard; busy_vec_o is registered (one-cycle update), no backpressure.
// An issue-time allocation overrides a same-cycle writeback clear of the same register.
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int NR_REG = NR_REG_DEF,
    parameter int AW     = $clog2(NR_REG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_en_i,
    input  logic [AW-1:0]     alloc_addr_i,
    input  logic              wen0_i,
    input  logic [AW-1:0]     waddr0_i,
    input  logic              wen1_i,
    input  logic [AW-1:0]     waddr1_i,
    output logic [NR_REG-1:0] busy_vec_o
);
    logic [NR_REG-1:0] busy_q;
    logic [NR_REG-1:0] busy_d;

    always_comb begin
        busy_d           = busy_q;
        busy_d[REG_ZERO] = 1'b0;
        for (int i = REG_ZERO + 1; i < NR_REG; i++) begin
            if (alloc_en_i && (alloc_addr_i == AW'(i))) begin
                busy_d[i] = 1'b1;
            end else if ((wen0_i && (waddr0_i == AW'(i))) ||
                         (wen1_i && (waddr1_i == AW'(i)))) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec_o = busy_q;
endmodule

// File: rtl/regfile_2w_bypass_sb.sv
// Two-write, NR_RD-read register file with optional write-to-read bypass and busy scoreboard.
// Reads are combinational (0 cycles), writes land at the next edge; no backpressure.
module regfile_2w_bypass_sb
    import rf_pkg::*;
#(
    parameter int  DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int  NR_REG     = NR_REG_DEF,
    parameter int  NR_RD      = 2,
    parameter int  BYPASS     = 1,
    localparam int AW         = $clog2(NR_REG)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NR_RD*AW-1:0]         rd_addr_i,
    output logic [NR_RD*DATA_WIDTH-1:0] rd_data_o,
    output logic [NR_RD-1:0]            rd_busy_o,
    input  logic                        wen0_i,
    input  logic [AW-1:0]               waddr0_i,
    input  logic [DATA_WIDTH-1:0]       wdata0_i,
    input  logic                        wen1_i,
    input  logic [AW-1:0]               waddr1_i,
    input  logic [DATA_WIDTH-1:0]       wdata1_i,
    input  logic                        alloc_en_i,
    input  logic [AW-1:0]               alloc_addr_i,
    output logic [NR_REG-1:0]           busy_vec_o
);
    localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);

    logic [DATA_WIDTH-1:0] regs_q [NR_REG];
    logic [NR_REG-1:0]     busy_vec;

    // Port 1 is assigned last so it wins an address collision with port 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NR_REG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (wen0_i && (waddr0_i != ZERO_A)) begin
                regs_q[waddr0_i] <= wdata0_i;
            end
            if (wen1_i && (waddr1_i != ZERO_A)) begin
                regs_q[waddr1_i] <= wdata1_i;
            end
        end
    end

    regfile_scoreboard #(
        .NR_REG (NR_REG),
        .AW     (AW)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_en_i   (alloc_en_i),
        .alloc_addr_i (alloc_addr_i),
        .wen0_i       (wen0_i),
        .waddr0_i     (waddr0_i),
        .wen1_i       (wen1_i),
        .waddr1_i     (waddr1_i),
        .busy_vec_o   (busy_vec)
    );

    assign busy_vec_o = busy_vec;

    for (genvar k = 0; k < NR_RD; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic          hit0;
        logic          hit1;
        logic          fwd;

        assign ra   = rd_addr_i[k*AW +: AW];
        assign hit0 = (BYPASS != 0) && wen0_i && (waddr0_i == ra);
        assign hit1 = (BYPASS != 0) && wen1_i && (waddr1_i == ra);
        // A completing write is forwarded, so its register is not a hazard.
        assign fwd  = hit0 || hit1;

        assign rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] =
            (ra == ZERO_A) ? '0 :
            hit1           ? wdata1_i :
            hit0           ? wdata0_i :
                             regs_q[ra];
        assign rd_busy_o[k] = (ra != ZERO_A) && busy_vec[ra] && !fwd;
    end
endmodule
